fifo_flush: RTL and testbench

Single-clock, synchronous-read FIFO with a one-cycle flush that discards all stored entries. It buffers narrow write data, returns each entry zero-extended on a 32-bit read port, and exports its live occupancy count. It sits between a producer that may need to abort queued work and a consumer that drains entries on demand.

---
 rtl/fifo_flush.sv | 94 +++++++++
 tb/tb_fifo_flush.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_flush.sv
// fifo_flush: single-clock synchronous-read FIFO with a one-cycle flush that
//   discards every stored entry. Read data is zero-extended to 32 bits.
// Latency: a write is counted directly after its edge and is readable from the
//   next edge; read data is registered, valid directly after the read edge.
// Backpressure: writes while full are dropped unless a read is accepted on
//   the same edge; reads while empty are ignored (no fall-through).
//
// Ports:
//   clock, reset                   - clock, async active-low reset
//   fifo_wr_valid_i/fifo_wr_data_i - enqueue request and data
//   fifo_rd_valid_i                - dequeue request
//   fifo_flush_i                   - synchronous flush, highest priority
//   fifo_empty_o/fifo_full_o       - occupancy flags
//   fifo_rd_data_o                 - last dequeued entry, zero-extended
//   fifo_curr_o                    - current occupancy 0..DEPTH
module fifo_flush #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_wr_valid_i,
  input  logic              fifo_rd_valid_i,
  input  logic              fifo_flush_i,
  input  logic [DATA_W-1:0] fifo_wr_data_i,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
  output logic [31:0]       fifo_rd_data_o,
  output logic [31:0]       fifo_curr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_rd_data;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  // A read is only ever accepted from stored entries, so a simultaneous
  // write into an empty FIFO never falls through to the read port.
  assign w_rd_acc = fifo_rd_valid_i && !w_empty && !fifo_flush_i;
  // When full, a same-edge read frees the slot the write lands in.
  assign w_wr_acc = fifo_wr_valid_i && (!w_full || w_rd_acc) && !fifo_flush_i;

  // Storage has no reset; contents after reset or flush are don't-care.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= fifo_wr_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else if (fifo_flush_i) begin
      // Read data deliberately holds across a flush.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= 32'(r_mem[r_rd_ptr]);
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_empty_o   = w_empty;
  assign fifo_full_o    = w_full;
  assign fifo_rd_data_o = r_rd_data;
  assign fifo_curr_o    = 32'(r_count);

endmodule

// File: tb/tb_fifo_flush.sv
// tb_fifo_flush: directed self-checking bench for fifo_flush (DATA_W=4, DEPTH=8).
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next.
// Backpressure: exercises drop-on-full, read-while-empty and flush priority.
module tb_fifo_flush;

  logic        clock;
  logic        reset;
  logic        fifo_wr_valid_i;
  logic        fifo_rd_valid_i;
  logic        fifo_flush_i;
  logic [3:0]  fifo_wr_data_i;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic [31:0] fifo_rd_data_o;
  logic [31:0] fifo_curr_o;

  int checks;
  int errors;

  fifo_flush #(.DATA_W(4), .DEPTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_wr_valid_i (fifo_wr_valid_i),
    .fifo_rd_valid_i (fifo_rd_valid_i),
    .fifo_flush_i    (fifo_flush_i),
    .fifo_wr_data_i  (fifo_wr_data_i),
    .fifo_empty_o    (fifo_empty_o),
    .fifo_full_o     (fifo_full_o),
    .fifo_rd_data_o  (fifo_rd_data_o),
    .fifo_curr_o     (fifo_curr_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus, let one rising edge take it, then idle inputs.
  task automatic cycle(input logic wr, input logic rd, input logic fl, input logic [3:0] d);
    fifo_wr_valid_i = wr;
    fifo_rd_valid_i = rd;
    fifo_flush_i    = fl;
    fifo_wr_data_i  = d;
    @(posedge clock);
    #1;
    fifo_wr_valid_i = 1'b0;
    fifo_rd_valid_i = 1'b0;
    fifo_flush_i    = 1'b0;
  endtask

  task automatic test_reset();
    fifo_wr_valid_i = 1'b0;
    fifo_rd_valid_i = 1'b0;
    fifo_flush_i    = 1'b0;
    fifo_wr_data_i  = 4'h0;
    reset = 1'b0;
    #12;
    checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty_o); end
    checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full_o); end
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL reset_curr got %0d want 0", fifo_curr_o); end
    checks++; if (fifo_rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", fifo_rd_data_o); end
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_write3();
    logic [3:0] vals [3];
    vals[0] = 4'hA; vals[1] = 4'h3; vals[2] = 4'h5;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, vals[i]);
      checks++; if (fifo_curr_o !== 32'(i + 1)) begin errors++; $display("FAIL write3_curr[%0d] got %0d want %0d", i, fifo_curr_o, i + 1); end
      checks++; if (fifo_empty_o !== 1'b0) begin errors++; $display("FAIL write3_empty[%0d] got %b want 0", i, fifo_empty_o); end
      checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("FAIL write3_full[%0d] got %b want 0", i, fifo_full_o); end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b0, 1'b1, 4'hE);
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL flush_curr got %0d want 0", fifo_curr_o); end
    checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", fifo_empty_o); end
    checks++; if (fifo_rd_data_o !== 32'h0) begin errors++; $display("FAIL flush_rd_data got %h want 0", fifo_rd_data_o); end
  endtask

  task automatic test_read();
    cycle(1'b1, 1'b0, 1'b0, 4'hD);
    cycle(1'b1, 1'b0, 1'b0, 4'h1);
    checks++; if (fifo_curr_o !== 32'd2) begin errors++; $display("FAIL read_pre_curr got %0d want 2", fifo_curr_o); end
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h0000000D) begin errors++; $display("FAIL read_first got %h want 0000000d", fifo_rd_data_o); end
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h00000001) begin errors++; $display("FAIL read_second got %h want 00000001", fifo_rd_data_o); end
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL read_curr got %0d want 0", fifo_curr_o); end
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h00000001) begin errors++; $display("FAIL read_empty_hold got %h want 00000001", fifo_rd_data_o); end
    checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL read_empty_flag got %b want 1", fifo_empty_o); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_drain [8];
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'(i));
    end
    checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", fifo_full_o); end
    checks++; if (fifo_curr_o !== 32'd8) begin errors++; $display("FAIL full_curr got %0d want 8", fifo_curr_o); end
    cycle(1'b1, 1'b0, 1'b0, 4'hF);
    checks++; if (fifo_curr_o !== 32'd8) begin errors++; $display("FAIL full_drop_curr got %0d want 8", fifo_curr_o); end
    cycle(1'b1, 1'b1, 1'b0, 4'hF);
    checks++; if (fifo_rd_data_o !== 32'h0) begin errors++; $display("FAIL full_rdwr_data got %h want 0", fifo_rd_data_o); end
    checks++; if (fifo_curr_o !== 32'd8) begin errors++; $display("FAIL full_rdwr_curr got %0d want 8", fifo_curr_o); end
    checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("FAIL full_rdwr_flag got %b want 1", fifo_full_o); end
    for (int i = 0; i < 7; i++) exp_drain[i] = 32'(i + 1);
    exp_drain[7] = 32'hF;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'h0);
      checks++; if (fifo_rd_data_o !== exp_drain[i]) begin errors++; $display("FAIL drain[%0d] got %h want %h", i, fifo_rd_data_o, exp_drain[i]); end
    end
    checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", fifo_empty_o); end
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL drain_curr got %0d want 0", fifo_curr_o); end
  endtask

  task automatic test_rdwr_empty();
    cycle(1'b1, 1'b1, 1'b0, 4'h9);
    checks++; if (fifo_curr_o !== 32'd1) begin errors++; $display("FAIL rdwr_empty_curr got %0d want 1", fifo_curr_o); end
    checks++; if (fifo_rd_data_o !== 32'hF) begin errors++; $display("FAIL rdwr_empty_hold got %h want 0000000f", fifo_rd_data_o); end
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h00000009) begin errors++; $display("FAIL rdwr_empty_next got %h want 00000009", fifo_rd_data_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'(i + 2));
    end
    checks++; if (fifo_curr_o !== 32'd5) begin errors++; $display("FAIL areset_pre_curr got %0d want 5", fifo_curr_o); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL areset_curr got %0d want 0", fifo_curr_o); end
    checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL areset_empty got %b want 1", fifo_empty_o); end
    checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", fifo_full_o); end
    checks++; if (fifo_rd_data_o !== 32'h0) begin errors++; $display("FAIL areset_rd_data got %h want 0", fifo_rd_data_o); end
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    cycle(1'b1, 1'b0, 1'b0, 4'h6);
    checks++; if (fifo_curr_o !== 32'd1) begin errors++; $display("FAIL post_reset_curr got %0d want 1", fifo_curr_o); end
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h00000006) begin errors++; $display("FAIL post_reset_read got %h want 00000006", fifo_rd_data_o); end
  endtask

  task automatic test_flush_hold();
    cycle(1'b1, 1'b0, 1'b0, 4'h4);
    fifo_flush_i    = 1'b1;
    fifo_wr_valid_i = 1'b1;
    fifo_wr_data_i  = 4'h7;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (fifo_curr_o !== 32'd0) begin errors++; $display("FAIL flush_hold_curr got %0d want 0", fifo_curr_o); end
    fifo_flush_i    = 1'b0;
    fifo_wr_valid_i = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    checks++; if (fifo_rd_data_o !== 32'h00000006) begin errors++; $display("FAIL flush_hold_rd got %h want 00000006", fifo_rd_data_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write3();
    test_flush();
    test_read();
    test_full_wrap();
    test_rdwr_empty();
    test_async_reset();
    test_flush_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
